// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing a multicycle RV64 subset datapath (ld, sd, R/I ALU, beq) over one shared memory port.
// Define MC_MEM_TIMEOUT_EN to trap after MEM_TIMEOUT consecutive unanswered memory wait cycles.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_timeout
);
  typedef enum logic [3:0] {
    FETCH, DECODE, ADDR, MEM_RD, MEM_WR, WB_MEM, EXEC_R, EXEC_I, WB_ALU, BEQ, TRAP
  } state_t;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  state_t state_q, state_d;
  logic illegal_q, illegal_d, mem_timeout_q, mem_timeout_d, timeout_hit;
`ifdef MC_MEM_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  // mem_req is low outside the three request states, so the counter also clears on leaving them
  always_comb begin
    wait_d = (mem_req && !mem_ready) ? wait_q + 8'd1 : 8'd0;
    timeout_hit = mem_req && !mem_ready && wait_q == 8'(MEM_TIMEOUT);
  end
  always_ff @(posedge clk) wait_q <= reset ? 8'd0 : wait_d;
`else
  logic unused_timeout;
  assign unused_timeout = |MEM_TIMEOUT;
  assign timeout_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      illegal_q <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      illegal_q <= illegal_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: state_d = (opcode == OP_LD || opcode == OP_SD) ? ADDR :
                        opcode == OP_R   ? EXEC_R :
                        opcode == OP_I   ? EXEC_I :
                        opcode == OP_BEQ ? BEQ : TRAP;
      ADDR:   state_d = opcode == OP_LD ? MEM_RD : MEM_WR;
      MEM_RD: if (mem_ready) state_d = WB_MEM;
      MEM_WR: if (mem_ready) state_d = FETCH;
      EXEC_R, EXEC_I: state_d = WB_ALU;
      WB_MEM, WB_ALU, BEQ: state_d = FETCH;
      default: state_d = TRAP;
    endcase
    if (timeout_hit) state_d = TRAP;
    illegal_d = illegal_q | (state_q == DECODE && state_d == TRAP);
    mem_timeout_d = mem_timeout_q | timeout_hit;
  end
  always_comb begin
    {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, aluop,
     reg_write, mem_to_reg, instr_done} = '0;
    illegal = illegal_q & ~reset;
    mem_timeout = mem_timeout_q & ~reset;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          alu_src_b = 2'b01;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE: alu_src_b = 2'b10;
        ADDR, EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          iord = 1'b1;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          iord = 1'b1;
          mem_we = 1'b1;
          instr_done = mem_ready;
        end
        WB_MEM: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          aluop = 2'b10;
        end
        WB_ALU: begin
          reg_write = 1'b1;
          instr_done = 1'b1;
        end
        BEQ: begin
          alu_src_a = 1'b1;
          aluop = 2'b01;
          pc_src = 1'b1;
          pc_write = zero;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed sequences plus randomized instruction stream checked against per-instruction expectations.
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0] alu_src_b, aluop;
  logic reg_write, mem_to_reg, instr_done, illegal, mem_timeout;
  logic [15:0] ov;
  int checks = 0, errors = 0;
  localparam logic [6:0] OP_LD = 7'b0000011, OP_SD = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011;
  always #5 clk = ~clk;
  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );
  // Output vector: {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, aluop, reg_write, mem_to_reg, instr_done, illegal, mem_timeout}
  assign ov = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, aluop,
               reg_write, mem_to_reg, instr_done, illegal, mem_timeout};

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    opcode = OP_LD;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      @(negedge clk); checks++;
      if (ov !== 16'h0000) begin errors++; $display("FAIL reset_hold cycle %0d: got %h expected 0000", i, ov); end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk); checks++;
    if (ov !== 16'h8080) begin errors++; $display("FAIL reset_release: got %h expected 8080", ov); end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype;
    logic [15:0] e[$] = '{16'h9880, 16'h0100, 16'h0240, 16'h0014, 16'h9880};
    do_reset;
    opcode = OP_R;
    mem_ready = 1'b1;
    foreach (e[i]) begin
      @(negedge clk); checks++;
      if (ov !== e[i]) begin errors++; $display("FAIL rtype cycle %0d: got %h expected %h", i, ov, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ld_wait;
    logic [15:0] e[$] = '{16'h9880, 16'h0100, 16'h0300, 16'hA000, 16'hA000, 16'hA000, 16'hA000, 16'h001C, 16'h9880};
    bit r[$] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    do_reset;
    opcode = OP_LD;
    foreach (e[i]) begin
      mem_ready = r[i];
      @(negedge clk); checks++;
      if (ov !== e[i]) begin errors++; $display("FAIL ld_wait cycle %0d: got %h expected %h", i, ov, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sd;
    logic [15:0] e[$] = '{16'h9880, 16'h0100, 16'h0300, 16'hE004, 16'h9880};
    do_reset;
    opcode = OP_SD;
    mem_ready = 1'b1;
    foreach (e[i]) begin
      @(negedge clk); checks++;
      if (ov !== e[i]) begin errors++; $display("FAIL sd cycle %0d: got %h expected %h", i, ov, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq;
    logic [15:0] e[$];
    for (int z = 1; z >= 0; z--) begin
      e = '{16'h9880, 16'h0100, (z != 0) ? 16'h0E24 : 16'h0624, 16'h9880};
      do_reset;
      opcode = OP_BEQ;
      zero = 1'(z);
      mem_ready = 1'b1;
      foreach (e[i]) begin
        @(negedge clk); checks++;
        if (ov !== e[i]) begin errors++; $display("FAIL beq zero=%0d cycle %0d: got %h expected %h", z, i, ov, e[i]); end
        @(posedge clk); #1;
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal;
    logic [15:0] e[$] = '{16'h9880, 16'h0100};
    do_reset;
    opcode = 7'b1111111;
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) e.push_back(16'h0002);
    foreach (e[i]) begin
      if (i >= 2) mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk); checks++;
      if (ov !== e[i]) begin errors++; $display("FAIL illegal cycle %0d: got %h expected %h", i, ov, e[i]); end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk); checks++;
    if (ov !== 16'h0000) begin errors++; $display("FAIL illegal_reset: got %h expected 0000", ov); end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk); checks++;
    if (ov !== 16'h8080) begin errors++; $display("FAIL illegal_restart: got %h expected 8080", ov); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [15:0] e[$] = '{16'h9880, 16'h0100, 16'h0300};
    do_reset;
    opcode = OP_SD;
    mem_ready = 1'b1;
    foreach (e[i]) begin
      @(negedge clk); checks++;
      if (ov !== e[i]) begin errors++; $display("FAIL reset_mid cycle %0d: got %h expected %h", i, ov, e[i]); end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk); checks++;
    if (ov !== 16'h0000) begin errors++; $display("FAIL reset_mid_memwr: got %h expected 0000", ov); end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk); checks++;
    if (ov !== 16'h8080) begin errors++; $display("FAIL reset_mid_fetch: got %h expected 8080", ov); end
    @(posedge clk); #1;
  endtask

`ifdef MC_MEM_TIMEOUT_EN
  task automatic test_timeout;
    logic [15:0] e[$] = '{16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h0001, 16'h0001, 16'h0001};
    logic [15:0] a[$] = '{16'h8080, 16'h8080, 16'h8080, 16'h9880, 16'h0100};
    bit r[$] = '{0, 0, 0, 1, 1};
    do_reset;
    opcode = OP_R;
    mem_ready = 1'b0;
    foreach (e[i]) begin
      @(negedge clk); checks++;
      if (ov !== e[i]) begin errors++; $display("FAIL timeout cycle %0d: got %h expected %h", i, ov, e[i]); end
      @(posedge clk); #1;
    end
    do_reset;
    foreach (a[i]) begin
      mem_ready = r[i];
      @(negedge clk); checks++;
      if (ov !== a[i]) begin errors++; $display("FAIL timeout_accept cycle %0d: got %h expected %h", i, ov, a[i]); end
      @(posedge clk); #1;
    end
  endtask
`endif

  // Expected per-instruction totals follow from latency and handshake rules, not from state sequencing
  task automatic test_random;
    logic [6:0] ops[5] = '{OP_R, OP_I, OP_LD, OP_SD, OP_BEQ};
    int base[5] = '{4, 4, 5, 4, 3};
    string nm[9] = '{"len", "req", "we", "iord", "irw", "pcw", "regw", "m2r", "done"};
    int t, fw, dw, z, mem, cyc, rq, ex[9], got[9], cnt[16];
    bit d;
    do_reset;
    for (int n = 0; n < 60; n++) begin
      t = int'($urandom_range(0, 4));
      fw = int'($urandom_range(0, 3));
      dw = int'($urandom_range(0, 3));
      z = int'($urandom_range(0, 1));
      mem = (t == 2 || t == 3) ? 1 : 0;
      opcode = ops[t];
      zero = 1'(z);
      cyc = 0;
      rq = 0;
      d = 1'b0;
      foreach (cnt[b]) cnt[b] = 0;
      do begin
        mem_ready = mem_req ? (rq == fw || rq == fw + 1 + dw) : 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
        if (mem_req) rq++;
        for (int b = 0; b < 16; b++) if (ov[b]) cnt[b]++;
        d = instr_done;
        @(posedge clk); #1;
      end while (!d && cyc < 40);
      ex = '{base[t] + fw + mem * dw, fw + 1 + mem * (dw + 1), (t == 3) ? dw + 1 : 0, mem * (dw + 1),
             1, 1 + ((t == 4 && z == 1) ? 1 : 0), (t < 3) ? 1 : 0, (t == 2) ? 1 : 0, 1};
      got = '{cyc, cnt[15], cnt[14], cnt[13], cnt[12], cnt[11], cnt[4], cnt[3], cnt[2]};
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (got[k] !== ex[k]) begin
          errors++;
          $display("FAIL random instr %0d op %b %s: got %0d expected %0d (fw=%0d dw=%0d zero=%0d)", n, ops[t], nm[k], got[k], ex[k], fw, dw, z);
        end
      end
      if (!d) do_reset;
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_ld_wait;
    test_sd;
    test_beq;
    test_illegal;
    test_reset_mid;
`ifdef MC_MEM_TIMEOUT_EN
    test_timeout;
`endif
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
